exc_sequencer: RTL and testbench
================================

Name: exc_sequencer

Overview:
- Multi-cycle exception/interrupt sequencer for the LEGv8 core, placed beside the main decoder and ALU decoder.
- Turns the decoder's invalid-opcode and ERET indications and the external IRQ line into an ordered redirect sequence.
- Owns the ELR (exception link register) and ESR (status code) and drives the vector/return redirect, the kill strobe and the IRQ acknowledge.
- Handles one exception at a time with no nesting; a second synchronous fault inside a handler halts the core.

Parameters:
N, 64, PC/ELR width in bits
EXC_VECTOR, 64'h0000_0000_0000_00D8, handler entry address
CNT_W, 8, width of saturating exception counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
pc  in  N  PC of the instruction currently being decoded
valid  in  1  pc/decoder outputs are a real instruction this cycle
NotAnInstr  in  1  decoder: opcode is not a legal instruction
ERet  in  1  decoder: instruction is ERET
ExtIRQ  in  1  external interrupt request, level, held until ExtIAck
ExcAck  in  1  fetch unit accepted the vector redirect
Exc  out  1  request redirect to EXC_VECTOR
ERetTaken  out  1  one-cycle redirect to ELR
target_pc  out  N  EXC_VECTOR while Exc, ELR while ERetTaken, else 0
kill  out  1  suppress regWrite/memWrite/Branch of current instruction
ELR  out  N  saved return PC
EStatus  out  4  exception cause code
ExtIAck  out  1  one-cycle IRQ acknowledge
in_handler  out  1  high in TAKE and HANDLER
halted  out  1  double fault; sticky until reset
exc_count  out  CNT_W  saturating count of exceptions taken

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Clock port clk, reset port reset.
- Reset (asserted low, any state, any cycle, including mid-TAKE):
  - state immediately RUN.
  - ELR, EStatus and exc_count go to 0.
  - All strobes go to 0: Exc, ERetTaken, ExtIAck, kill, halted, in_handler.
- Cause codes: 4'b0001 external IRQ; 4'b0010 invalid opcode; 4'b0011 ERET outside handler; 4'b1111 double fault.
- States: RUN, TAKE, HANDLER, RETURN, HALT.
- RUN:
  - Event: (valid & NotAnInstr), (valid & ERet), or ExtIRQ.
  - Priority: NotAnInstr > ERet > ExtIRQ. A lower-priority IRQ stays pending because the line is level.
  - kill is combinational, high in the event cycle.
  - At the following edge: ELR<=pc, EStatus<=code, exc_count++ (saturating at all-ones), state->TAKE.
  - ELR = pc for all causes: the faulting instruction, or for an IRQ the killed, not-yet-executed instruction.
  - IRQ while valid=0 is still taken, with ELR=pc.
- TAKE:
  - Exc=1, target_pc=EXC_VECTOR, kill=1, in_handler=1.
  - Exc holds until ExcAck is sampled high. ExcAck in the first TAKE cycle is accepted (1-cycle minimum).
  - On the ExcAck edge: state->HANDLER; ExtIAck=1 for exactly the next cycle if EStatus==0001.
  - ExcAck outside TAKE is ignored.
- HANDLER:
  - IRQs masked; ExtIRQ ignored. in_handler=1.
  - valid & NotAnInstr: kill=1; next edge EStatus<=1111, halted<=1, state->HALT. ELR is not overwritten.
  - valid & ERet (and not NotAnInstr): kill=1; next edge state->RETURN.
- RETURN (exactly 1 cycle):
  - ERetTaken=1, target_pc=ELR, kill=1, in_handler=0.
  - Next edge: EStatus<=0, state->RUN. ELR retains its value.
  - An IRQ still asserted is evaluated in the first RUN cycle.
- HALT: kill=1, halted=1, no redirects; only reset exits.
- Exc and ERetTaken are never high in the same cycle.
- Latency: 1 cycle from event to Exc. 2 cycles minimum from event to ExtIAck.
- Pending IRQ is counted again only when it is re-taken; exc_count never wraps.

Test Plan:
1. Reset low with ExtIRQ=1 -> all outputs 0. Release; next cycle kill=1. Next edge Exc=1, target_pc=0xD8, EStatus=0001, ELR=pc (e.g. 0x40), exc_count=1.
2. Invalid opcode at pc=0x20; ExcAck held 0 for 3 cycles then 1 -> Exc high 4 cycles, ExtIAck never high, EStatus=0010, ELR=0x20. Then ERet in HANDLER -> ERetTaken=1 with target_pc=0x20, then EStatus=0.
3. Same cycle valid&NotAnInstr and ExtIRQ at pc=0x10 -> EStatus=0010. After ERET return, the next RUN cycle takes the IRQ: EStatus=0001, ELR=pc of that cycle, exc_count=2.
4. NotAnInstr inside HANDLER -> next cycle halted=1, EStatus=1111, kill stays 1. ELR unchanged. ERet/ExtIRQ ignored until reset.
5. ERet at pc=0x30 in RUN -> EStatus=0011, ELR=0x30, Exc path taken. Drive reset low during TAKE -> Exc drops to 0 asynchronously and state is RUN after release.
6. Force 300 back-to-back IRQ exceptions (CNT_W=8) -> exc_count saturates at 255.

Source files
------------

// File: rtl/exc_sequencer.sv
// exc_sequencer: exception / interrupt sequencer for the LEGv8 core.
//
// Turns the decoder's invalid-opcode and ERET indications plus the level
// external IRQ into an ordered redirect sequence. It owns ELR and EStatus
// and drives the vector/return redirect, the kill strobe and the IRQ
// acknowledge. One exception at a time; a fault inside a handler halts.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   pc         PC of the instruction currently being decoded
//   valid      pc/decoder outputs describe a real instruction this cycle
//   NotAnInstr decoder: opcode is illegal
//   ERet       decoder: instruction is ERET
//   ExtIRQ     external interrupt request (level, held until ExtIAck)
//   ExcAck     fetch unit accepted the vector redirect
//   Exc        redirect request to EXC_VECTOR
//   ERetTaken  one-cycle redirect to ELR
//   target_pc  EXC_VECTOR while Exc, ELR while ERetTaken, else 0
//   kill       suppress architectural side effects of the current instr
//   ELR        saved return PC
//   EStatus    exception cause code
//   ExtIAck    one-cycle IRQ acknowledge
//   in_handler high in TAKE and HANDLER
//   halted     double fault, sticky until reset
//   exc_count  saturating count of exceptions taken
module exc_sequencer #(
  parameter int              N          = 64,
  parameter logic [N-1:0]    EXC_VECTOR = {{(N-8){1'b0}}, 8'hD8},
  parameter int              CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pc,
  input  logic             valid,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic             ExtIRQ,
  input  logic             ExcAck,
  output logic             Exc,
  output logic             ERetTaken,
  output logic [N-1:0]     target_pc,
  output logic             kill,
  output logic [N-1:0]     ELR,
  output logic [3:0]       EStatus,
  output logic             ExtIAck,
  output logic             in_handler,
  output logic             halted,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [2:0] S_RUN     = 3'd0;
  localparam logic [2:0] S_TAKE    = 3'd1;
  localparam logic [2:0] S_HANDLER = 3'd2;
  localparam logic [2:0] S_RETURN  = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [3:0] C_NONE   = 4'b0000;
  localparam logic [3:0] C_IRQ    = 4'b0001;
  localparam logic [3:0] C_ILLOP  = 4'b0010;
  localparam logic [3:0] C_ERET   = 4'b0011;
  localparam logic [3:0] C_DOUBLE = 4'b1111;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] run_code;
  logic       run_event;
  logic       hnd_fault;
  logic       hnd_eret;
  logic       iack_q;

  // Cause selection in RUN: illegal opcode beats ERET beats IRQ. A losing
  // IRQ is not lost; the level line is simply re-evaluated later.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    run_code = C_NONE;
    if (valid && NotAnInstr)  run_code = C_ILLOP;
    else if (valid && ERet)   run_code = C_ERET;
    else if (ExtIRQ)          run_code = C_IRQ;
  end

  assign run_event = (run_code != C_NONE);
  assign hnd_fault = valid && NotAnInstr;
  assign hnd_eret  = valid && ERet && !NotAnInstr;

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:     if (run_event) state_nxt = S_TAKE;
      S_TAKE:    if (ExcAck)    state_nxt = S_HANDLER;
      S_HANDLER: begin
        if (hnd_fault)     state_nxt = S_HALT;
        else if (hnd_eret) state_nxt = S_RETURN;
      end
      S_RETURN:  state_nxt = S_RUN;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      ELR       <= '0;
      EStatus   <= C_NONE;
      exc_count <= '0;
      iack_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      iack_q <= (state == S_TAKE) && ExcAck && (EStatus == C_IRQ);
      case (state)
        S_RUN: begin
          if (run_event) begin
            ELR     <= pc;
            EStatus <= run_code;
            if (exc_count != {CNT_W{1'b1}}) exc_count <= exc_count + 1'b1;
          end
        end
        S_HANDLER: if (hnd_fault) EStatus <= C_DOUBLE;
        S_RETURN:  EStatus <= C_NONE;
        default:   ;
      endcase
    end
  end

  assign Exc        = (state == S_TAKE);
  assign ERetTaken  = (state == S_RETURN);
  assign in_handler = (state == S_TAKE) || (state == S_HANDLER);
  assign halted     = (state == S_HALT);
  assign ExtIAck    = iack_q;

  always_comb begin
    target_pc = '0;
    if (state == S_TAKE)        target_pc = EXC_VECTOR;
    else if (state == S_RETURN) target_pc = ELR;
  end

  // kill in RUN is a combinational view of the inputs, so it is gated
  // with reset: a held IRQ must not raise kill while the core is in reset.
  always_comb begin
    kill = 1'b0;
    case (state)
      S_RUN:     kill = run_event;
      S_TAKE:    kill = 1'b1;
      S_HANDLER: kill = hnd_fault || hnd_eret;
      S_RETURN:  kill = 1'b1;
      S_HALT:    kill = 1'b1;
      default:   kill = 1'b0;
    endcase
    kill = kill && reset;
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios followed by a
// randomized run, all compared each cycle against a behavioural model.
module tb_exc_sequencer;

  localparam int N = 64;
  localparam int CNT_W = 8;
  localparam logic [N-1:0] VEC = 64'hD8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     pc;
  logic             valid, NotAnInstr, ERet, ExtIRQ, ExcAck;
  logic             Exc, ERetTaken, kill, ExtIAck, in_handler, halted;
  logic [N-1:0]     target_pc, ELR;
  logic [3:0]       EStatus;
  logic [CNT_W-1:0] exc_count;

  exc_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .valid(valid),
    .NotAnInstr(NotAnInstr), .ERet(ERet), .ExtIRQ(ExtIRQ), .ExcAck(ExcAck),
    .Exc(Exc), .ERetTaken(ERetTaken), .target_pc(target_pc), .kill(kill),
    .ELR(ELR), .EStatus(EStatus), .ExtIAck(ExtIAck),
    .in_handler(in_handler), .halted(halted), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: where the core is in the exception story.
  typedef enum {RUNNING, VECTORING, IN_HANDLER, RETURNING, DEAD} phase_t;
  phase_t       m_phase;
  logic [N-1:0] m_elr;
  logic [3:0]   m_esr;
  int           m_cnt;
  logic         m_iack;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = RUNNING; m_elr = '0; m_esr = 4'd0; m_cnt = 0; m_iack = 1'b0;
  endtask

  function automatic logic [3:0] cause_now();
    if (valid && NotAnInstr) return 4'd2;
    if (valid && ERet)       return 4'd3;
    if (ExtIRQ)              return 4'd1;
    return 4'd0;
  endfunction

  // Compare every output against the model, then advance the model over
  // one rising edge. Called just after a falling edge with inputs set.
  task automatic step();
    logic         e_kill;
    logic [N-1:0] e_tgt;
    logic [3:0]   c;
    #2;
    c = cause_now();
    case (m_phase)
      RUNNING:    e_kill = (c != 0);
      IN_HANDLER: e_kill = valid && (NotAnInstr || ERet);
      default:    e_kill = 1'b1;
    endcase
    e_tgt = (m_phase == VECTORING) ? VEC : (m_phase == RETURNING) ? m_elr : '0;
    check("Exc",        Exc,        (m_phase == VECTORING));
    check("ERetTaken",  ERetTaken,  (m_phase == RETURNING));
    check("target_pc",  target_pc,  e_tgt);
    check("kill",       kill,       e_kill);
    check("ELR",        ELR,        m_elr);
    check("EStatus",    EStatus,    m_esr);
    check("ExtIAck",    ExtIAck,    m_iack);
    check("in_handler", in_handler, (m_phase == VECTORING) || (m_phase == IN_HANDLER));
    check("halted",     halted,     (m_phase == DEAD));
    check("exc_count",  exc_count,  N'(m_cnt));
    @(posedge clk);
    m_iack = 1'b0;
    case (m_phase)
      RUNNING: if (c != 0) begin
        m_elr = pc; m_esr = c; m_phase = VECTORING;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      VECTORING: if (ExcAck) begin
        m_phase = IN_HANDLER; m_iack = (m_esr == 4'd1);
      end
      IN_HANDLER: begin
        if (valid && NotAnInstr) begin m_esr = 4'hF; m_phase = DEAD; end
        else if (valid && ERet)  m_phase = RETURNING;
      end
      RETURNING: begin m_esr = 4'd0; m_phase = RUNNING; end
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 0; NotAnInstr = 0; ERet = 0; ExtIRQ = 0; ExcAck = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    reset = 1'b0; pc = 64'h40;
    idle_inputs();
    ExtIRQ = 1;
    model_reset();

    // 1: reset with IRQ held -> quiet outputs; IRQ taken after release.
    @(negedge clk); #2;
    check("rst_Exc",   Exc, 0);       check("rst_kill", kill, 0);
    check("rst_ERet",  ERetTaken, 0); check("rst_iack", ExtIAck, 0);
    check("rst_inh",   in_handler, 0); check("rst_halt", halted, 0);
    check("rst_ELR",   ELR, 0);       check("rst_ESR", EStatus, 0);
    check("rst_cnt",   exc_count, 0); check("rst_tgt", target_pc, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("t1_kill", kill, 1);
    step();
    check("t1_Exc", Exc, 1);    check("t1_tgt", target_pc, 64'hD8);
    check("t1_ESR", EStatus, 1); check("t1_ELR", ELR, 64'h40);
    check("t1_cnt", exc_count, 1);
    ExcAck = 1; step(); ExcAck = 0;
    check("t1_iack", ExtIAck, 1);
    ExtIRQ = 0; valid = 1; ERet = 1; step();
    idle_inputs(); step();

    // 2: illegal opcode with a slow ExcAck.
    pc = 64'h20; valid = 1; NotAnInstr = 1; step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("t2_Exc_hold", Exc, 1);
      step();
    end
    check("t2_Exc_last", Exc, 1);
    ExcAck = 1; step(); ExcAck = 0;
    check("t2_iack", ExtIAck, 0); check("t2_ESR", EStatus, 2); check("t2_ELR", ELR, 64'h20);
    valid = 1; ERet = 1; step(); idle_inputs();
    check("t2_ERetTaken", ERetTaken, 1); check("t2_tgt", target_pc, 64'h20);
    step();
    check("t2_ESR_clr", EStatus, 0);

    // 3: illegal opcode wins over a same-cycle IRQ; IRQ taken after return.
    apply_reset();
    pc = 64'h10; valid = 1; NotAnInstr = 1; ExtIRQ = 1; step();
    valid = 0; NotAnInstr = 0;
    check("t3_ESR", EStatus, 2);
    ExcAck = 1; step(); ExcAck = 0;
    valid = 1; ERet = 1; step(); valid = 0; ERet = 0;
    step();
    pc = 64'h50; step();
    check("t3_ESR_irq", EStatus, 1); check("t3_ELR", ELR, 64'h50); check("t3_cnt", exc_count, 2);
    ExcAck = 1; step(); ExcAck = 0; ExtIRQ = 0;
    valid = 1; ERet = 1; step(); idle_inputs(); step();

    // 4: double fault inside the handler.
    pc = 64'h60; valid = 1; NotAnInstr = 1; step(); idle_inputs();
    ExcAck = 1; step(); ExcAck = 0;
    pc = 64'h70; valid = 1; NotAnInstr = 1; step(); NotAnInstr = 0;
    check("t4_halt", halted, 1); check("t4_ESR", EStatus, 4'hF);
    check("t4_kill", kill, 1);   check("t4_ELR", ELR, 64'h60);
    ERet = 1; ExtIRQ = 1;
    for (int i = 0; i < 4; i++) step();
    check("t4_still_halt", halted, 1);
    idle_inputs();

    // 5: ERET outside a handler; reset pulled during TAKE.
    apply_reset();
    pc = 64'h30; valid = 1; ERet = 1; step(); idle_inputs();
    check("t5_ESR", EStatus, 3); check("t5_ELR", ELR, 64'h30); check("t5_Exc", Exc, 1);
    #2 reset = 1'b0;
    #1 check("t5_async_Exc", Exc, 0); check("t5_async_inh", in_handler, 0);
    @(negedge clk);
    reset = 1'b1; model_reset();
    step();
    check("t5_run_cnt", exc_count, 0);

    // 6: counter saturation with back-to-back IRQs.
    apply_reset();
    ExtIRQ = 1; ExcAck = 1;
    for (int i = 0; i < 1200; i++) begin
      valid = (m_phase == IN_HANDLER); ERet = valid;
      pc = N'(i * 4);
      step();
    end
    check("t6_sat", exc_count, 255);
    idle_inputs();

    // Randomized traffic against the model.
    apply_reset();
    begin
      int dead_cycles = 0;
      for (int i = 0; i < 600; i++) begin
        valid      = $urandom_range(0, 1);
        NotAnInstr = ($urandom_range(0, 9) == 0);
        ERet       = ($urandom_range(0, 3) == 0);
        ExtIRQ     = ($urandom_range(0, 2) == 0);
        ExcAck     = $urandom_range(0, 1);
        pc         = {$urandom, $urandom};
        step();
        if (m_phase == DEAD) dead_cycles++;
        if (dead_cycles > 3) begin
          dead_cycles = 0;
          apply_reset();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
